// File: rtl/mem_stage_top_if.sv
// MEM-stage bus: pipeline inputs from EX/MEM and the registered MEM/WB outputs.
// The slave modport is the stage itself; the master drives it.
interface mem_stage_top_if #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 5,
  parameter int NB_REG  = 5
);
  logic               enable_i;
  logic [NB_DATA-1:0] alu_result_i;
  logic [NB_DATA-1:0] write_data_i;
  logic               mem_read_i;
  logic               mem_write_i;
  logic [1:0]         mem_size_i;
  logic               mem_unsigned_i;
  logic [1:0]         mem_to_reg_i;
  logic               reg_write_i;
  logic [NB_REG-1:0]  reg_dest_i;
  logic [6:0]         pc_i;
  logic               halt_i;
  logic [NB_ADDR-1:0] debug_addr_i;

  logic [NB_DATA-1:0] mem_data_o;
  logic [NB_DATA-1:0] alu_result_o;
  logic [6:0]         pc_o;
  logic [1:0]         mem_to_reg_o;
  logic               reg_write_o;
  logic [NB_REG-1:0]  reg_dest_o;
  logic               halt_o;
  logic               misaligned_o;
  logic [NB_DATA-1:0] debug_data_o;

  modport slave (
    input  enable_i, alu_result_i, write_data_i,
    input  mem_read_i, mem_write_i, mem_size_i,
    input  mem_unsigned_i, mem_to_reg_i, reg_write_i,
    input  reg_dest_i, pc_i, halt_i, debug_addr_i,
    output mem_data_o, alu_result_o, pc_o,
    output mem_to_reg_o, reg_write_o, reg_dest_o,
    output halt_o, misaligned_o, debug_data_o
  );

  modport master (
    output enable_i, alu_result_i, write_data_i,
    output mem_read_i, mem_write_i, mem_size_i,
    output mem_unsigned_i, mem_to_reg_i, reg_write_i,
    output reg_dest_i, pc_i, halt_i, debug_addr_i,
    input  mem_data_o, alu_result_o, pc_o,
    input  mem_to_reg_o, reg_write_o, reg_dest_o,
    input  halt_o, misaligned_o, debug_data_o
  );
endinterface

// File: rtl/mem_stage_top.sv
// MIPS MEM stage + MEM/WB register with byte/half/word data memory.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module mem_stage_top #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 5,
  parameter int NB_REG  = 5
) (
  input logic            clock_i,
  input logic            reset_n_i,
  mem_stage_top_if.slave bus
);
  localparam int NWORDS = 2 ** NB_ADDR;

  logic [NB_DATA-1:0] mem [NWORDS];

  logic [NB_ADDR-1:0] idx;
  logic [1:0]         a_lo;
  logic [1:0]         lane;
  logic               is_byte;
  logic               is_half;
  logic               mis;
  logic [NB_DATA-1:0] rd_word;
  logic [7:0]         ld_byte;
  logic [15:0]        ld_half;
  logic [NB_DATA-1:0] ld_val;
  logic [NB_DATA-1:0] wr_rep;
  logic [3:0]         wr_mask;
  logic [NB_DATA-1:0] st_word;
  logic               do_store;

  assign idx     = bus.alu_result_i[NB_ADDR+1:2];
  assign a_lo    = bus.alu_result_i[1:0];
  assign is_byte = bus.mem_size_i == 2'b00;
  assign is_half = bus.mem_size_i == 2'b01;
  assign rd_word = mem[idx];

  // Half/word lanes are forced aligned; a trap build flags instead.
  always_comb begin
    lane = 2'b00;
    unique case (1'b1)
      is_byte: lane = a_lo;
      is_half: lane = {a_lo[1], 1'b0};
      default: lane = 2'b00;
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  assign mis = (bus.mem_read_i | bus.mem_write_i) &
               ((is_half & a_lo[0]) |
                (!is_byte & !is_half & (a_lo != 2'b00)));
`else
  assign mis = 1'b0;
`endif

  assign ld_byte = rd_word[{lane, 3'b000} +: 8];
  assign ld_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    ld_val  = '0;
    wr_rep  = bus.write_data_i;
    wr_mask = 4'b1111;
    unique case (1'b1)
      is_byte: begin
        ld_val = bus.mem_unsigned_i ?
          {{(NB_DATA-8){1'b0}}, ld_byte} :
          {{(NB_DATA-8){ld_byte[7]}}, ld_byte};
        wr_rep  = {4{bus.write_data_i[7:0]}};
        wr_mask = 4'b0001 << lane;
      end
      is_half: begin
        ld_val = bus.mem_unsigned_i ?
          {{(NB_DATA-16){1'b0}}, ld_half} :
          {{(NB_DATA-16){ld_half[15]}}, ld_half};
        wr_rep  = {2{bus.write_data_i[15:0]}};
        wr_mask = lane[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        ld_val  = rd_word;
        wr_rep  = bus.write_data_i;
        wr_mask = 4'b1111;
      end
    endcase
  end

  always_comb begin
    st_word = rd_word;
    for (int k = 0; k < 4; k++) begin
      if (wr_mask[k]) st_word[8*k +: 8] = wr_rep[8*k +: 8];
    end
  end

  assign do_store = bus.enable_i & bus.mem_write_i & !mis;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < NWORDS; i++) mem[i] <= '0;
      bus.mem_data_o   <= '0;
      bus.alu_result_o <= '0;
      bus.pc_o         <= '0;
      bus.mem_to_reg_o <= '0;
      bus.reg_write_o  <= 1'b0;
      bus.reg_dest_o   <= '0;
      bus.halt_o       <= 1'b0;
      bus.misaligned_o <= 1'b0;
      bus.debug_data_o <= '0;
    end else begin
      // Debug port sees the pre-store word of a same-cycle write.
      bus.debug_data_o <= mem[bus.debug_addr_i];
      if (do_store) mem[idx] <= st_word;
      if (bus.enable_i) begin
        bus.mem_data_o <= (bus.mem_read_i & !mis) ?
                          ld_val : '0;
        bus.alu_result_o <= bus.alu_result_i;
        bus.pc_o         <= bus.pc_i;
        bus.mem_to_reg_o <= bus.mem_to_reg_i;
        bus.reg_write_o  <= bus.reg_write_i & !mis;
        bus.reg_dest_o   <= bus.reg_dest_i;
        if (bus.halt_i) bus.halt_o <= 1'b1;
        if (mis) bus.misaligned_o <= 1'b1;
      end
    end
  end
endmodule
